// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter sharing one i2c_master among N_REQ
// requesters, with start and transfer timeouts that abort via m_rst.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   req                per-requester level request
//   cmd_in, wdata_in   per-requester {addr,rw} and write bytes (8b slices)
//   gnt, done          one-hot grant; one-cycle completion pulse
//   err, rdata         timeout flag and read byte, valid with done
//   m_en, m_rst        master enable pulse and active-high master reset
//   m_cmd, m_data      command/write byte held for the whole transfer
//   m_busy             master busy
//   m_read_data        master read byte
module i2c_arbiter #(
   parameter int N_REQ     = 3,
   parameter int EN_CYCLES = 2,
   parameter int START_TO  = 16,
   parameter int XFER_TO   = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] cmd_in,
   input  logic [8*N_REQ-1:0] wdata_in,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic               err,
   output logic [7:0]         rdata,
   output logic               m_en,
   output logic               m_rst,
   output logic [7:0]         m_cmd,
   output logic [7:0]         m_data,
   input  logic               m_busy,
   input  logic [7:0]         m_read_data
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [15:0] EN_LAST    = 16'(EN_CYCLES - 1);
   localparam logic [15:0] START_LAST = 16'(START_TO - 1);
   localparam logic [15:0] XFER_LAST  = 16'(XFER_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_BUSY,
      WAIT_DONE,
      COMPLETE,
      ABORT
   } state_t;

   state_t        state;
   logic [IW-1:0] last_gnt;
   logic [IW-1:0] cur;
   logic [IW-1:0] win;
   logic          found;
   logic [15:0]   cnt;
   logic [15:0]   cnt_inc;
   logic [7:0]    cmd_a [N_REQ];
   logic [7:0]    wd_a  [N_REQ];

   // Saturating increment: a stuck counter must never wrap back below
   // its timeout threshold.
   assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         cmd_a[i] = cmd_in[i*8 +: 8];
         wd_a[i]  = wdata_in[i*8 +: 8];
      end
   end

   // Search starts one past the last winner, so the previous owner is
   // considered last and cannot win twice while others wait.
   always_comb begin
      int j;
      j     = 0;
      win   = last_gnt;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(last_gnt) + k) % N_REQ;
         if (!found && req[IW'(j)]) begin
            win   = IW'(j);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         rdata    <= 8'h00;
         m_en     <= 1'b0;
         m_rst    <= 1'b1;
         m_cmd    <= 8'h00;
         m_data   <= 8'h00;
         last_gnt <= IW'(N_REQ - 1);
         cur      <= '0;
         cnt      <= '0;
      end else begin
         m_rst <= 1'b0;
         done  <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  cur    <= win;
                  gnt    <= N_REQ'(1) << win;
                  m_cmd  <= cmd_a[win];
                  m_data <= wd_a[win];
                  m_en   <= 1'b1;
                  cnt    <= '0;
                  state  <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (cnt >= EN_LAST) begin
                  m_en  <= 1'b0;
                  cnt   <= '0;
                  state <= WAIT_BUSY;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WAIT_BUSY: begin
               if (m_busy) begin
                  cnt   <= '0;
                  state <= WAIT_DONE;
               end else if (cnt >= START_LAST) begin
                  cnt   <= '0;
                  done  <= gnt;
                  err   <= 1'b1;
                  m_rst <= 1'b1;
                  state <= ABORT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WAIT_DONE: begin
               if (!m_busy) begin
                  cnt   <= '0;
                  done  <= gnt;
                  err   <= 1'b0;
                  if (m_cmd[0]) rdata <= m_read_data;
                  state <= COMPLETE;
               end else if (cnt >= XFER_LAST) begin
                  cnt   <= '0;
                  done  <= gnt;
                  err   <= 1'b1;
                  m_rst <= 1'b1;
                  state <= ABORT;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            COMPLETE, ABORT: begin
               gnt      <= '0;
               err      <= 1'b0;
               last_gnt <= cur;
               cnt      <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scoreboard bench for i2c_arbiter with a behavioural
// i2c_master stand-in (normal, silent and stuck-busy modes).
module tb_i2c_arbiter;

   localparam int M_NORMAL = 0;
   localparam int M_SILENT = 1;
   localparam int M_STUCK  = 2;

   typedef struct {
      int         idx;
      logic       err;
      logic [7:0] rd;
      logic [7:0] cmd;
      logic [7:0] dat;
      int         lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [7:0]  cmd_a [3];
   logic [7:0]  wd_a  [3];
   logic [23:0] cmd_in;
   logic [23:0] wdata_in;
   logic [2:0]  gnt;
   logic [2:0]  done;
   logic        err;
   logic [7:0]  rdata;
   logic        m_en;
   logic        m_rst;
   logic [7:0]  m_cmd;
   logic [7:0]  m_data;
   logic        m_busy;
   logic [7:0]  m_read_data;

   int   vectors;
   int   miscompares;
   int   mode;
   logic [7:0] rd_val;
   exp_t sb [$];

   assign cmd_in   = {cmd_a[2], cmd_a[1], cmd_a[0]};
   assign wdata_in = {wd_a[2], wd_a[1], wd_a[0]};

   i2c_arbiter #(
      .N_REQ(3), .EN_CYCLES(2), .START_TO(16), .XFER_TO(100)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .cmd_in(cmd_in), .wdata_in(wdata_in),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .m_en(m_en), .m_rst(m_rst), .m_cmd(m_cmd), .m_data(m_data),
      .m_busy(m_busy), .m_read_data(m_read_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int idx, input logic e, input logic [7:0] rd,
                       input logic [7:0] c, input logic [7:0] d,
                       input int lat);
      exp_t x;
      x.idx = idx; x.err = e; x.rd = rd;
      x.cmd = c; x.dat = d; x.lat = lat;
      sb.push_back(x);
   endtask

   task automatic wait_done(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done != 3'b000) seen = 1'b1;
      end
      if (!seen) begin
         miscompares++;
         $display("FAIL %s_timeout: got no done want done", nm);
      end
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_gnt"}, 32'(gnt), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_err"}, 32'(err), 0);
      chk({nm, "_rdata"}, 32'(rdata), 0);
      chk({nm, "_m_en"}, 32'(m_en), 0);
      chk({nm, "_m_rst"}, 32'(m_rst), 1);
      chk({nm, "_m_cmd"}, 32'(m_cmd), 0);
      chk({nm, "_m_data"}, 32'(m_data), 0);
   endtask

   // Master stand-in: two cycles after m_en falls it raises busy; in
   // normal mode it drops busy four cycles later with rd_val, in stuck
   // mode it stays busy until m_rst is seen.
   initial begin : master
      logic en_q;
      en_q        = 1'b0;
      m_busy      = 1'b0;
      m_read_data = 8'h00;
      forever begin
         @(negedge clk);
         if (en_q && !m_en && rst && mode != M_SILENT) begin
            repeat (2) @(negedge clk);
            m_busy = 1'b1;
            if (mode == M_NORMAL) begin
               repeat (4) @(negedge clk);
               m_read_data = rd_val;
               m_busy      = 1'b0;
            end else begin
               for (int i = 0; i < 300 && !m_rst; i++) @(negedge clk);
               m_busy = 1'b0;
            end
         end
         en_q = m_en;
      end
   end

   initial begin : monitor
      int   hi_cnt;
      int   since_fall;
      logic en_q;
      logic done_q;
      exp_t e;
      hi_cnt = 0; since_fall = 0; en_q = 1'b0; done_q = 1'b0;
      forever begin
         @(negedge clk);
         since_fall++;
         if (en_q && !m_en) begin
            since_fall = 0;
            chk("m_en_width", 32'(hi_cnt), 2);
         end
         hi_cnt = m_en ? hi_cnt + 1 : 0;
         en_q   = m_en;
         if (m_en && m_busy) begin
            miscompares++;
            $display("FAIL overlap: got m_en=1 m_busy=1 want not both");
         end
         if (done_q && rst) chk("m_rst_after_done", 32'(m_rst), 0);
         if (done != 3'b000) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 0);
            end else begin
               e = sb.pop_front();
               chk("done", 32'(done), 32'(3'b001 << e.idx));
               chk("gnt", 32'(gnt), 32'(3'b001 << e.idx));
               chk("err", 32'(err), 32'(e.err));
               chk("m_rst_at_done", 32'(m_rst), 32'(e.err));
               chk("rdata", 32'(rdata), 32'(e.rd));
               chk("m_cmd", 32'(m_cmd), 32'(e.cmd));
               chk("m_data", 32'(m_data), 32'(e.dat));
               chk("latency", 32'(since_fall), 32'(e.lat));
            end
         end
         done_q = (done != 3'b000);
      end
   end

   initial begin : stim
      logic [7:0] rd_tab [4];
      vectors = 0; miscompares = 0;
      mode = M_NORMAL; rd_val = 8'h00;
      rst = 1'b0; req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cmd_a[i] = 8'h00;
         wd_a[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      @(negedge clk);
      chk("m_rst_release", 32'(m_rst), 0);

      // Single read from 0x77
      cmd_a[0] = 8'hEF; wd_a[0] = 8'h00; rd_val = 8'hAA;
      push(0, 1'b0, 8'hAA, 8'hEF, 8'h00, 7);
      req[0] = 1'b1;
      wait_done("single_read");
      req[0] = 1'b0;

      // Reset while the master is busy: no done, outputs back to reset
      mode = M_STUCK;
      cmd_a[1] = 8'hEF; wd_a[1] = 8'h11;
      req[1] = 1'b1;
      for (int i = 0; i < 50 && !m_busy; i++) @(negedge clk);
      chk("busy_before_reset", 32'(m_busy), 1);
      repeat (5) @(negedge clk);
      rst = 1'b0; req = 3'b000;
      @(negedge clk);
      chk_reset_vals("mid_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("m_rst_release2", 32'(m_rst), 0);

      // Contention: all three held, grants 0,1,2,0
      mode = M_NORMAL;
      cmd_a[0] = 8'hEF; wd_a[0] = 8'h01;
      cmd_a[1] = 8'h50; wd_a[1] = 8'h02;
      cmd_a[2] = 8'h25; wd_a[2] = 8'h03;
      rd_tab[0] = 8'h3C; rd_tab[1] = 8'h77;
      rd_tab[2] = 8'hC3; rd_tab[3] = 8'h5A;
      push(0, 1'b0, 8'h3C, 8'hEF, 8'h01, 7);
      push(1, 1'b0, 8'h3C, 8'h50, 8'h02, 7);
      push(2, 1'b0, 8'hC3, 8'h25, 8'h03, 7);
      push(0, 1'b0, 8'h5A, 8'hEF, 8'h01, 7);
      rd_val = rd_tab[0];
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_done("contention");
         if (k < 3) rd_val = rd_tab[k+1];
      end
      req = 3'b000;

      // Absent slave at 0x12: master still completes normally
      cmd_a[1] = 8'h25; wd_a[1] = 8'h44; rd_val = 8'hFF;
      push(1, 1'b0, 8'hFF, 8'h25, 8'h44, 7);
      req[1] = 1'b1;
      wait_done("missing_slave");
      req[1] = 1'b0;

      // Start timeout: busy never rises
      mode = M_SILENT;
      cmd_a[2] = 8'h50; wd_a[2] = 8'h99;
      push(2, 1'b1, 8'hFF, 8'h50, 8'h99, 16);
      req[2] = 1'b1;
      wait_done("start_to");
      req[2] = 1'b0;

      // Transfer timeout: busy stuck high for XFER_TO clocks
      mode = M_STUCK;
      cmd_a[0] = 8'hEF; wd_a[0] = 8'h05;
      push(0, 1'b1, 8'hFF, 8'hEF, 8'h05, 103);
      req[0] = 1'b1;
      wait_done("xfer_to");
      req[0] = 1'b0;

      repeat (5) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3: number of requesters, range 2..8.
REQ-002 SHALL have parameter EN_CYCLES, default 2: m_en pulse width in clocks.
REQ-003 SHALL have parameter START_TO, default 16: maximum clocks from m_en fall to m_busy rise.
REQ-004 SHALL have parameter XFER_TO, default 65535: maximum clocks m_busy may stay high; 16-bit counter.
REQ-005 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-006 SHALL have port rst  in  1  reset; synchronous, active-low.
REQ-007 SHALL have port req  in  N_REQ  per-requester level request; held until that requester's done.
REQ-008 SHALL have port cmd_in  in  8*N_REQ  per-requester command byte, {addr[6:0], rw}, in slice i*8+:8.
REQ-009 SHALL have port wdata_in  in  8*N_REQ  per-requester write byte.
REQ-010 SHALL have port gnt  out  N_REQ  one-hot grant, high from grant cycle through done cycle.
REQ-011 SHALL have port done  out  N_REQ  one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port err  out  1  valid with done; 1 = timeout abort.
REQ-013 SHALL have port rdata  out  8  read byte, valid with done.
REQ-014 SHALL have port m_en  out  1  to i2c_master en.
REQ-015 SHALL have port m_rst  out  1  to i2c_master rst, active-high.
REQ-016 SHALL have port m_cmd  out  8  to i2c_master cmd.
REQ-017 SHALL have port m_data  out  8  to i2c_master data.
REQ-018 SHALL have port m_busy  in  1  from i2c_master busy.
REQ-019 SHALL have port m_read_data  in  8  from i2c_master read_data.

Function
REQ-020 SHALL implement states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, COMPLETE, ABORT.
REQ-021 IDLE: when any req is high at cycle t, SHALL select the winner by round-robin starting at (last_gnt+1) mod N_REQ, then enter LAUNCH at t+1.
REQ-022 At t+1 SHALL assert gnt[i], latch cmd_in/wdata_in slice i into m_cmd/m_data, and hold both constant until leaving COMPLETE/ABORT.
REQ-023 LAUNCH: SHALL drive m_en=1 for exactly EN_CYCLES clocks (t+1..t+EN_CYCLES), then enter WAIT_BUSY.
REQ-024 WAIT_BUSY: on m_busy=1 SHALL enter WAIT_DONE; if START_TO clocks elapse without m_busy, SHALL enter ABORT.
REQ-025 WAIT_DONE: on m_busy=0 SHALL enter COMPLETE; if m_busy stays high XFER_TO clocks, SHALL enter ABORT.
REQ-026 COMPLETE, one cycle: done[i]=1, err=0; rdata=m_read_data if m_cmd[0]=1, else rdata holds; last_gnt=i; next state IDLE with gnt cleared.
REQ-027 ABORT, one cycle: m_rst=1, done[i]=1, err=1, rdata holds, last_gnt=i; next state IDLE.
REQ-028 Earliest next grant is the cycle after done; back-to-back requests SHALL NOT overlap.
REQ-029 A req deasserting mid-transfer SHALL NOT cancel the transfer; done is still pulsed.
REQ-030 Timeout counters SHALL clear on every state entry and saturate, never wrap.
REQ-031 A requester SHALL NOT win two consecutive grants while another req is pending.

Reset
REQ-032 rst=0 at a posedge SHALL force IDLE from any state, including mid-transfer.
REQ-033 Reset values: gnt=0, done=0, err=0, rdata=0, m_en=0, m_rst=1 while rst=0, m_cmd=0, m_data=0, last_gnt=N_REQ-1 (requester 0 wins first).
REQ-034 After rst returns to 1, m_rst SHALL be 0; the first grant SHALL occur no earlier than the cycle after req is sampled.

Verification
REQ-035 Single read: req[0], cmd_in[0]=8'hEF (0x77 read), master returns 8'hAA -> m_en high 2 cycles, done[0] pulse, err=0, rdata=8'hAA.
REQ-036 Contention: req=3'b111 held -> grants in order 0,1,2,0; each gnt one-hot; no m_en while the previous busy is high.
REQ-037 Missing slave: cmd 0x25 (0x12 read), master completes normally -> done, err=0; the bench checks master NACK separately.
REQ-038 Start timeout: m_busy tied 0 -> ABORT 16 cycles after m_en falls; m_rst 1-cycle pulse; done with err=1.
REQ-039 Transfer timeout with XFER_TO=100, m_busy stuck 1 -> err=1 done after 100 cycles; m_rst pulse.
REQ-040 Reset mid-WAIT_DONE -> next cycle all outputs at reset values; no done pulse is issued.
